// File: rtl/clb_param_if.sv
// Signal bundle for clb_param: LUT inputs, storage clock enable,
// serial configuration chain and the two block outputs.
interface clb_param_if #(
    parameter int LUT_K = 4
);
    logic [LUT_K-1:0] IN;
    logic             CE;
    logic             CFG_EN;
    logic             CFG_DIN;
    logic             CFG_DOUT;
    logic             CFG_DONE;
    logic             X;
    logic             Y;

    modport master (
        output IN, CE, CFG_EN, CFG_DIN,
        input  CFG_DOUT, CFG_DONE, X, Y
    );

    modport slave (
        input  IN, CE, CFG_EN, CFG_DIN,
        output CFG_DOUT, CFG_DONE, X, Y
    );
endinterface

// File: rtl/clb_param.sv
// Configurable logic block: K-input LUT (optionally split in two halves), one
// storage element with set/reset selects, loaded through a serial config chain.
module clb_param #(
    parameter int LUT_K = 4
) (
    input logic        K,
    input logic        RST,
    clb_param_if.slave bus
);
    localparam int M    = 2 ** LUT_K;
    localparam int CFGW = M + 11;
    localparam int CNTW = $clog2(CFGW);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(CFGW - 1);

    typedef enum logic {IDLE, LOADING} state_t;

    state_t            state, state_nx;
    logic [CFGW-1:0]   shreg, cfg, word_nx;
    logic [CNTW-1:0]   cnt;
    logic              cfg_valid, cfg_valid_nx, cfg_done, done_nx;
    logic              last;
    logic              q;

    logic [M-1:0]      mem;
    logic              split, fbsel, dsel;
    logic [1:0]        ssel, rsel, xsel, ysel;
    logic [LUT_K-1:0]  addr;
    logic              f, g, s, r, d, x_mux, y_mux;

    assign word_nx = {shreg[CFGW-2:0], bus.CFG_DIN};
    assign last    = bus.CFG_EN && (cnt == CNT_LAST);

    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    always_comb begin
        state_nx     = state;
        cfg_valid_nx = cfg_valid || last;
        if (bus.CFG_EN) begin
            state_nx = last ? IDLE : LOADING;
        end
        done_nx = cfg_valid_nx && (state_nx == IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge K) begin
        if (RST) state <= IDLE;
        else     state <= state_nx;
    end

    // Reset outranks a shift on the same edge; CFG_EN=0 freezes a partial load.
    always_ff @(posedge K) begin
        if (RST) begin
            shreg     <= '0;
            cnt       <= '0;
            cfg       <= '0;
            cfg_valid <= 1'b0;
            cfg_done  <= 1'b0;
        end else begin
            if (bus.CFG_EN) begin
                shreg <= word_nx;
                cnt   <= last ? '0 : cnt + 1'b1;
            end
            if (last) cfg <= word_nx;
            cfg_valid <= cfg_valid_nx;
            cfg_done  <= done_nx;
        end
    end

    assign mem   = cfg[M-1:0];
    assign split = cfg[M];
    assign fbsel = cfg[M+1];
    assign ssel  = cfg[M+3:M+2];
    assign rsel  = cfg[M+5:M+4];
    assign xsel  = cfg[M+7:M+6];
    assign ysel  = cfg[M+9:M+8];
    assign dsel  = cfg[M+10];

    always_comb begin
        addr = bus.IN;
        if (fbsel) addr[0] = q;
        if (split) begin
            f = mem[{1'b0, addr[LUT_K-2:0]}];
            g = mem[{1'b1, addr[LUT_K-2:0]}];
        end else begin
            f = mem[addr];
            g = f;
        end
        unique case (ssel)
            2'b01:   s = f;
            2'b10:   s = bus.IN[LUT_K-1];
            default: s = 1'b0;
        endcase
        unique case (rsel)
            2'b01:   r = g;
            2'b10:   r = bus.IN[0];
            default: r = 1'b0;
        endcase
        d = dsel ? g : f;
    end

    always_ff @(posedge K) begin
        if (RST) begin
            q <= 1'b0;
        end else if (cfg_valid && bus.CE) begin
            if (r)      q <= 1'b0;
            else if (s) q <= 1'b1;
            else        q <= d;
        end
    end

    always_comb begin
        x_mux = 1'b0;
        y_mux = 1'b0;
        if (cfg_valid) begin
            unique case (xsel)
                2'b00:   x_mux = f;
                2'b01:   x_mux = g;
                default: x_mux = q;
            endcase
            unique case (ysel)
                2'b00:   y_mux = q;
                2'b01:   y_mux = g;
                default: y_mux = f;
            endcase
        end
    end

    assign bus.X        = x_mux;
    assign bus.Y        = y_mux;
    assign bus.CFG_DOUT = shreg[CFGW-1];
    assign bus.CFG_DONE = cfg_done;
endmodule
